ps2kbd_ctrl: RTL and testbench
==============================

Name: ps2kbd_ctrl

Overview:
- Wishbone slave that receives PS/2 keyboard scan codes on ps2kbd_clk/ps2kbd_data and buffers them in a FIFO.
- The CPU reads codes through the I/O sub-bus at a free slot (p4) of the BASE 12 io mmu.
- Raises a level interrupt to interrupt_encoder while codes are pending.
- Device-to-host receive only; the block never drives the PS/2 lines.

Parameters:
- FIFO_AW, 4, log2 FIFO depth (depth 16 entries of 8 bits).
- TIMEOUT, 2000, clk_i cycles without a PS/2 falling edge before a partial frame is discarded (200 us at 10 MHz).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- bus  slave  if_wb  Wishbone slave (cyc, stb, we, adr, sel, dat_i, dat_o, ack); 32-bit data, adr[3:2] selects register.
- ps2_clk  input  1  raw PS/2 clock (asynchronous).
- ps2_data  input  1  raw PS/2 data (asynchronous).
- interrupt  output  1  level interrupt: irq_en AND FIFO not empty.

Behaviour:
- Reset (rst_ni=0, takes effect immediately): ack=0, dat_o=0, interrupt=0, FIFO empty, irq_en=0, sticky flags=0, receiver IDLE, synchronizers=1.
- Input conditioning: 2-FF synchronizer on each PS/2 line, then a third register for edge detection.
  - fall = prev & ~cur on the synchronized clock.
  - Data is sampled on the same clk_i cycle as fall.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on fall with data=0 (start bit), go to SHIFT with bitcnt=0. A fall with data=1 is ignored.
  - SHIFT: each fall shifts data in LSB first. bitcnt 0..7 are data, 8 is parity, 9 is stop. After the stop bit, go to CHECK.
  - CHECK (one cycle): frame is valid if parity makes the 9 bits odd and stop=1.
    - Valid and FIFO not full: push the byte.
    - Valid and FIFO full: drop the byte and set ovf.
    - Invalid: drop the byte and set ferr.
    - Return to IDLE.
- Timeout: in SHIFT, a counter counts cycles since the last fall. When it reaches TIMEOUT, return to IDLE, discard the frame and set ferr. No push occurs.
- FIFO: 2^FIFO_AW x 8, read/write pointers one bit wider than FIFO_AW; count = wptr - rptr.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - At full, a simultaneous pop then push is allowed, because the pop frees a slot first.
- Registers, indexed by adr[3:2]:
  - 0 DATA, read: dat_o = {24'h0, head byte}, and the FIFO pops on the ack cycle. If the FIFO is empty, dat_o=0 and there is no pop. Writes are ignored.
  - 1 STATUS, read: bit0=not empty, bit1=full, bit2=ovf, bit3=ferr, bits[8+FIFO_AW:8]=count, all other bits 0. Write: bits 2 and 3 clear ovf and ferr (write 1 to clear).
  - 2 CTRL, R/W: bit0=irq_en, other bits read 0.
  - 3: reads 0, writes ignored.
- Handshake:
  - ack is registered: asserted the cycle after cyc&stb&~ack and held for exactly one cycle.
  - Back-to-back accesses therefore complete every 2 cycles.
  - Side effects (pop, write, clear) occur only on the cycle ack is asserted.
  - dat_o is valid while ack=1.
- Sticky flag priority: if a set and a write-clear of the same flag occur in the same cycle, the set wins.
- interrupt is registered and updates one cycle after a change in irq_en or FIFO emptiness.

Optional Feature:
- PS2KBD_BREAK_FILTER_EN
  - Defined: the receiver tracks a prefix flag. Byte 0xF0 is not pushed and sets the flag. The next valid byte is then discarded and clears the flag. Net effect: only make codes are queued (0xE0 is still pushed). The flag clears on reset and on a timeout.
  - Undefined: every valid byte, including 0xF0 and the byte after it, is pushed.

Test Plan:
- Reset, then read STATUS -> dat_o=0, interrupt=0. Read DATA -> 0x00, count stays 0.
- Send frame 0x1C (start 0, data LSB first, parity 0, stop 1) with irq_en=1 -> STATUS bit0=1 and count=1, interrupt=1. Read DATA -> 0x1C; interrupt falls to 0 one cycle later.
- Send 0x1C with parity bit 1 -> no push, STATUS bit3=1. Write STATUS 0x8 -> bit3=0.
- Stop after 5 bits for TIMEOUT+10 cycles, then send full frame 0x5A -> ferr=1, FIFO holds only 0x5A.
- Send 17 frames 0x01..0x11 -> count=16, full=1, ovf=1. Sixteen DATA reads return 0x01..0x10 in order.
- Sequence F0,1C: with PS2KBD_BREAK_FILTER_EN -> count=0. Without it -> count=2, reads return 0xF0 then 0x1C.

Source files
------------

// File: rtl/ps2kbd_ctrl.sv
// PS/2 keyboard receiver with a 2^FIFO_AW x 8 scan-code FIFO behind a Wishbone slave.
// Define PS2KBD_BREAK_FILTER_EN to drop 0xF0 break prefixes and the byte that follows them.
module ps2kbd_ctrl #(
  parameter int FIFO_AW = 4,
  parameter int TIMEOUT = 2000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        interrupt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;

  rx_state_t          state, state_nxt;
  logic [2:0]         clk_sync;
  logic [1:0]         dat_sync;
  logic [9:0]         shreg;
  logic [3:0]         bitcnt;
  logic [TW-1:0]      timer;
  logic               fall, ps2_bit, timed_out, frame_ok, keep;
  logic               push, pop, set_ovf, set_ferr, clr_ovf, clr_ferr;
  logic               ovf, ferr, irq_en;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wptr, rptr, count;
  logic               full, empty;
  logic               req, rd, wr;
  logic [1:0]         reg_sel;
  logic [31:0]        rd_mux, status;
  logic               unused;

  // Synchronizers idle high so reset never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign ps2_bit = dat_sync[1];

  assign timed_out = (state == SHIFT) && !fall && (timer == TW'(TIMEOUT));
  assign frame_ok  = (^shreg[8:0]) & shreg[9];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall && !ps2_bit) state_nxt = SHIFT;
      SHIFT:   if (fall && bitcnt == 4'd9) state_nxt = CHECK;
               else if (timed_out)         state_nxt = IDLE;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg  <= '0;
      bitcnt <= '0;
      timer  <= '0;
    end else begin
      if (state == SHIFT && fall) begin
        shreg  <= {ps2_bit, shreg[9:1]};
        bitcnt <= bitcnt + 4'd1;
      end else if (state != SHIFT) begin
        bitcnt <= '0;
      end
      timer <= (state == SHIFT && !fall) ? timer + TW'(1) : '0;
    end
  end

`ifdef PS2KBD_BREAK_FILTER_EN
  logic brk;

  // Any valid byte re-arms the prefix flag: 0xF0 sets it, everything else clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          brk <= 1'b0;
    else if (timed_out)                   brk <= 1'b0;
    else if (state == CHECK && frame_ok)  brk <= (shreg[7:0] == 8'hF0);
  end

  assign keep = (shreg[7:0] != 8'hF0) && !brk;
`else
  assign keep = 1'b1;
`endif

  // A same-cycle pop frees a slot, so a push at full is still accepted.
  assign push     = (state == CHECK) && frame_ok && keep && !(full && !pop);
  assign set_ovf  = (state == CHECK) && frame_ok && keep && full && !pop;
  assign set_ferr = ((state == CHECK) && !frame_ok) || timed_out;

  assign count = wptr - rptr;
  assign full  = count[FIFO_AW];
  assign empty = (wptr == rptr);

  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= shreg[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Side effects fire on the edge that raises ack, so dat_o reflects the pre-pop head.
  assign req      = wb_cyc && wb_stb && !wb_ack;
  assign rd       = req && !wb_we;
  assign wr       = req && wb_we;
  assign reg_sel  = wb_adr[3:2];
  assign pop      = rd && (reg_sel == 2'd0) && !empty;
  assign clr_ovf  = wr && (reg_sel == 2'd1) && wb_sel[0] && wb_dat_i[2];
  assign clr_ferr = wr && (reg_sel == 2'd1) && wb_sel[0] && wb_dat_i[3];

  assign status = {{(23 - FIFO_AW){1'b0}}, count, 4'b0, ferr, ovf, full, !empty};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    rd_mux = empty ? 32'h0 : {24'h0, mem[rptr[FIFO_AW-1:0]]};
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {31'h0, irq_en};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack    <= 1'b0;
      wb_dat_o  <= '0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      ferr      <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      wb_ack   <= req;
      wb_dat_o <= rd ? rd_mux : 32'h0;
      if (wr && reg_sel == 2'd2 && wb_sel[0]) irq_en <= wb_dat_i[0];
      ovf       <= set_ovf  || (ovf  && !clr_ovf);
      ferr      <= set_ferr || (ferr && !clr_ferr);
      interrupt <= irq_en && !empty;
    end
  end

  assign unused = &{1'b0, wb_sel[3:1], wb_adr[1:0], wb_dat_i[31:4], wb_dat_i[1]};

endmodule

// File: tb/tb_ps2kbd_ctrl.sv
// Self-checking bench for ps2kbd_ctrl: directed frames plus random traffic checked
// against a queue-based model of the keyboard FIFO, sticky flags and interrupt.
module tb_ps2kbd_ctrl;

  localparam int TIMEOUT = 2000;
  localparam int HALF    = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_adr = '0, wb_sel = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        ps2_clk = 1'b1, ps2_data = 1'b1;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit m_ovf = 0, m_ferr = 0, m_brk = 0, m_irq_en = 0;

  ps2kbd_ctrl #(.FIFO_AW(4), .TIMEOUT(TIMEOUT)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_sel   (wb_sel),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack   (wb_ack),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .interrupt(interrupt)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wb_xfer(input logic [1:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] q);
    bit got = 0;
    @(negedge clk_i);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = {a, 2'b00};
    wb_sel = 4'hF; wb_dat_i = d;
    q = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (wb_ack) begin q = wb_dat_o; got = 1; break; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wb_ack_timeout observed=0 expected=1");
    end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] q);
    wb_xfer(a, 1'b0, 32'h0, q);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, dummy);
  endtask

  // Drives nbits of an 11-bit device-to-host frame; data changes while clock is high.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(10);
  endtask

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ferr = 1;
      return;
    end
`ifdef PS2KBD_BREAK_FILTER_EN
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (m_brk)      begin m_brk = 0; return; end
`endif
    if (mq.size() == 16) m_ovf = 1;
    else                 mq.push_back(b);
  endfunction

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) return 32'h0;
    return {24'h0, mq.pop_front()};
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s = '0;
    s[0]    = (mq.size() != 0);
    s[1]    = (mq.size() == 16);
    s[2]    = m_ovf;
    s[3]    = m_ferr;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  task automatic frame(input logic [7:0] b, input bit bad_par);
    send_frame(b, bad_par, 11);
    model_frame(b, !bad_par);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] q;
    wb_read(2'd1, q);
    check(tag, q, model_status());
  endtask

  task automatic check_data(input string tag);
    logic [31:0] q;
    wb_read(2'd0, q);
    check(tag, q, model_pop());
  endtask

  task automatic check_irq(input string tag);
    wait_cyc(2);
    check(tag, {31'h0, interrupt}, {31'h0, m_irq_en && mq.size() != 0});
  endtask

  initial begin
    logic [31:0] q;
    int          r;
    logic [7:0]  b;

    #1;
    check("rst_ack", {31'h0, wb_ack}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_irq", {31'h0, interrupt}, 32'h0);
    wait_cyc(3);
    rst_ni = 1'b1;
    wait_cyc(3);

    // Empty device after reset.
    check_status("empty_status");
    check("empty_irq", {31'h0, interrupt}, 32'h0);
    wb_read(2'd0, q);
    check("empty_data", q, 32'h0);
    check_status("empty_status_after_read");
    check("ack_one_cycle", {31'h0, wb_ack}, 32'h1);
    @(posedge clk_i); #1;
    check("ack_drops", {31'h0, wb_ack}, 32'h0);

    // Single good frame with interrupts enabled.
    wb_write(2'd2, 32'h1);
    m_irq_en = 1;
    wb_read(2'd2, q);
    check("ctrl_readback", q, 32'h1);
    frame(8'h1C, 0);
    check_status("one_status");
    check("one_irq", {31'h0, interrupt}, 32'h1);
    wb_read(2'd0, q);
    check("one_data", q, 32'h1C);
    void'(model_pop());
    check("irq_still_high", {31'h0, interrupt}, 32'h1);
    @(posedge clk_i); #1;
    check("irq_falls", {31'h0, interrupt}, 32'h0);

    // Parity error, then write-1-to-clear.
    frame(8'h1C, 1);
    check_status("parity_ferr");
    wb_write(2'd1, 32'h8);
    m_ferr = 0;
    check_status("ferr_cleared");

    // Truncated frame times out; the following frame is still received.
    send_frame(8'h35, 0, 5);
    wait_cyc(TIMEOUT + 10);
    m_ferr = 1;
    m_brk  = 0;
    frame(8'h5A, 0);
    check_status("timeout_status");
    check_data("timeout_data");
    check_status("timeout_drained");
    wb_write(2'd1, 32'hC);
    m_ferr = 0;
    m_ovf  = 0;

    // Overflow: 17 frames into a 16-entry FIFO.
    for (int i = 1; i <= 17; i++) frame(8'(i), 0);
    check_status("full_status");
    for (int i = 0; i < 16; i++) check_data("full_drain");
    check_status("full_drained");
    wb_write(2'd1, 32'h4);
    m_ovf = 0;

    // Break prefix handling.
    frame(8'hF0, 0);
    frame(8'h1C, 0);
    wb_read(2'd1, q);
`ifdef PS2KBD_BREAK_FILTER_EN
    check("brk_count", {27'h0, q[12:8]}, 32'd0);
`else
    check("brk_count", {27'h0, q[12:8]}, 32'd2);
`endif
    check("brk_status", q, model_status());
    while (mq.size() != 0) check_data("brk_data");

    // Random traffic against the model.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 7);
      if (r <= 2) begin
        b = 8'($urandom_range(0, 255));
        frame(b, $urandom_range(0, 5) == 0);
      end else if (r <= 4) begin
        check_data("rnd_data");
      end else if (r == 5) begin
        check_status("rnd_status");
      end else if (r == 6) begin
        q = 32'($urandom_range(0, 15));
        wb_write(2'd1, q);
        if (q[2]) m_ovf  = 0;
        if (q[3]) m_ferr = 0;
      end else begin
        m_irq_en = ($urandom_range(0, 1) == 1);
        wb_write(2'd2, {31'h0, m_irq_en});
      end
      check_irq("rnd_irq");
    end

    while (mq.size() != 0) check_data("final_drain");
    check_status("final_status");
    check_irq("final_irq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
